// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI target (CPOL=0, CPHA=0), MSB first, DATA_W bits per word.
// All SPI pins are oversampled in the clk domain, so clk must run at least 4x SCLK.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk_i     SPI clock from master
//   cs_n_i     chip select from master, active low
//   mosi_i     serial data from master
//   miso_o     serial data to master, 0 while not selected
//   tx_data_i  word to transmit, sampled at frame start and at each word boundary
//   rx_data_o  last complete received word
//   rx_valid_o new-word strobe (1-clk pulse, or a level with the overrun option)
//   busy_o     high while the synchronized chip select is active
//
// Optional build macro SPI_SLAVE_OVERRUN_EN:
//   adds rx_ack_i / overrun_o. rx_valid_o is then held until rx_ack_i, and a
//   word completing while rx_valid_o is still pending sets the sticky overrun_o.
//
// Parameters: DATA_W (>= 2), SYNC_STAGES (>= 2).
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | not selected; miso_o low, SCLK edges ignored
// ACTIVE | selected; shift on SCLK edges, words complete every DATA_W rises
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic              rx_ack_i,
    output logic              overrun_o,
`endif
    output logic              busy_o
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    // The bit currently on the wire lives in miso_q; tx_shift holds the rest.
    logic [DATA_W-2:0]      tx_shift_q, tx_shift_d;
    // The last received bit is merged in directly when the word completes.
    logic [DATA_W-2:0]      rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   word_done_q, word_done_d;
    logic                   miso_q, miso_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                   overrun_q, overrun_d;
`endif

    logic              sclk_s, cs_n_s, mosi_s;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic              word_complete;
    logic [DATA_W-1:0] rx_word;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        cs_n_s = cs_sync_q[SYNC_STAGES-1];
        mosi_s = mosi_sync_q[SYNC_STAGES-1];

        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_n_s;

        sclk_rise = sclk_s & ~sclk_prev_q;
        sclk_fall = ~sclk_s & sclk_prev_q;
        cs_fall   = ~cs_n_s & cs_prev_q;
        cs_rise   = cs_n_s & ~cs_prev_q;

        rx_word = {rx_shift_q, mosi_s};

        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_done_d   = word_done_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        busy_d        = busy_q;
        word_complete = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    busy_d      = 1'b1;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    miso_d      = tx_data_i[DATA_W-1];
                    tx_shift_d  = tx_data_i[DATA_W-2:0];
                    rx_shift_d  = '0;
                end
            end
            ST_ACTIVE: begin
                // Deselect wins over any SCLK edge seen in the same clk.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    miso_d      = 1'b0;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word[DATA_W-2:0];
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d     = '0;
                        word_complete = 1'b1;
                        word_done_d   = 1'b1;
                        rx_data_d     = rx_word;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else if (sclk_fall) begin
                    // First fall after a completed word starts the next tx word.
                    if (bit_cnt_q == '0 && word_done_q) begin
                        miso_d     = tx_data_i[DATA_W-1];
                        tx_shift_d = tx_data_i[DATA_W-2:0];
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-2];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SPI_SLAVE_OVERRUN_EN
        // An ack in the same clk as a completion keeps the new word pending.
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (rx_ack_i) begin
            overrun_d = 1'b0;
        end else if (word_complete && rx_valid_q) begin
            overrun_d = 1'b1;
        end
        if (word_complete) begin
            rx_valid_d = 1'b1;
        end else if (rx_ack_i) begin
            rx_valid_d = 1'b0;
        end
`else
        rx_valid_d = word_complete;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q   <= overrun_d;
`endif
        end
    end

    assign miso_o     = miso_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = busy_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign overrun_o  = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed mode-0 frames plus a word-level model of what the
// slave must report, compared against the DUT outputs on every falling clk edge.
module tb_spi_slave;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;
    localparam int LAT         = SYNC_STAGES + 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              sclk_i    = 1'b0;
    logic              cs_n_i    = 1'b1;
    logic              mosi_i    = 1'b0;
    logic [DATA_W-1:0] tx_data_i = '0;
    logic              miso_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              busy_o;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic              rx_ack_i  = 1'b1;
    logic              overrun_o;
`endif

    int errors = 0;
    int checks = 0;

    spi_slave #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sclk_i(sclk_i),
        .cs_n_i(cs_n_i),
        .mosi_i(mosi_i),
        .miso_o(miso_o),
        .tx_data_i(tx_data_i),
        .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ack_i(rx_ack_i),
        .overrun_o(overrun_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: the slave sees the pins SYNC_STAGES+1 clks late, collects
    // mosi on every SCLK rise while selected, and reports each 8th bit as a word.
    typedef struct packed {
        logic cs_n;
        logic sclk;
        logic mosi;
    } pins_t;
    localparam pins_t IDLE_PINS = 3'b100;

    pins_t       hist [SYNC_STAGES+2];
    pins_t       cur, prv;
    logic        m_active  = 1'b0;
    int          m_nbits   = 0;
    logic [7:0]  m_bits    = '0;
    logic [7:0]  m_rx_data = '0;
    logic        m_valid   = 1'b0;
    logic        m_ovr     = 1'b0;
    logic        m_complete;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int k = 0; k < SYNC_STAGES + 2; k++) hist[k] = IDLE_PINS;
                m_active = 1'b0; m_nbits = 0; m_bits = '0;
                m_rx_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
            end else begin
                for (int k = SYNC_STAGES + 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = {cs_n_i, sclk_i, mosi_i};
                cur = hist[SYNC_STAGES];
                prv = hist[SYNC_STAGES+1];
                m_complete = 1'b0;
                if (!m_active) begin
                    if (prv.cs_n && !cur.cs_n) begin
                        m_active = 1'b1;
                        m_nbits  = 0;
                    end
                end else if (cur.cs_n && !prv.cs_n) begin
                    m_active = 1'b0;
                    m_nbits  = 0;
                end else if (cur.sclk && !prv.sclk) begin
                    m_bits = {m_bits[6:0], cur.mosi};
                    m_nbits++;
                    if (m_nbits == 8) begin
                        m_rx_data  = m_bits;
                        m_nbits    = 0;
                        m_complete = 1'b1;
                    end
                end
`ifdef SPI_SLAVE_OVERRUN_EN
                if (rx_ack_i) m_ovr = 1'b0;
                else if (m_complete && m_valid) m_ovr = 1'b1;
                if (m_complete) m_valid = 1'b1;
                else if (rx_ack_i) m_valid = 1'b0;
`else
                m_valid = m_complete;
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cmp_rx_valid", 32'(rx_valid_o), 32'(m_valid));
            check("cmp_rx_data", 32'(rx_data_o), 32'(m_rx_data));
            check("cmp_busy", 32'(busy_o), 32'(m_active));
            if (!m_active) check("cmp_miso_idle", 32'(miso_o), 32'h0);
`ifdef SPI_SLAVE_OVERRUN_EN
            check("cmp_overrun", 32'(overrun_o), 32'(m_ovr));
`endif
        end
    end

    // Master side: nbits MSB-first bits of mo; samples miso on each rise and
    // reports when rx_valid_o appears (in falling clk edges after the rise that
    // drove it) and how many falling edges it was seen high for.
    task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] nxt,
                        output logic [7:0] mi, output int lat, output int width);
        mi = '0;
        lat = -1;
        width = 0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi_i = mo[i];
            repeat (HALF) @(negedge clk);
            sclk_i = 1'b1;
            mi[i] = miso_o;
            for (int j = 1; j <= HALF; j++) begin
                @(negedge clk);
                if (rx_valid_o) begin
                    width++;
                    if (lat < 0) begin
                        lat = j;
                        tx_data_i = nxt;
                    end
                end
            end
            sclk_i = 1'b0;
        end
    endtask

    task automatic frame_start();
        cs_n_i = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        cs_n_i = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    logic [7:0] mi;
    int         lat, width;

    initial begin
        repeat (4) @(negedge clk);
        check("rst_miso", 32'(miso_o), 32'h0);
        check("rst_rx_data", 32'(rx_data_o), 32'h0);
        check("rst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single word
        tx_data_i = 8'hC5;
        frame_start();
        check("w1_busy", 32'(busy_o), 32'h1);
        xfer(8'h3A, 8, 8'hC5, mi, lat, width);
        check("w1_master_rx", 32'(mi), 32'hC5);
        check("w1_latency", 32'(lat), 32'(LAT));
        check("w1_pulse_width", 32'(width), 32'h1);
        check("w1_rx_data", 32'(rx_data_o), 32'h3A);
        frame_end();
        check("w1_busy_off", 32'(busy_o), 32'h0);
        check("w1_miso_off", 32'(miso_o), 32'h0);

        // back-to-back words under one CS
        tx_data_i = 8'h0F;
        frame_start();
        xfer(8'hA5, 8, 8'hF0, mi, lat, width);
        check("b2b_master_rx0", 32'(mi), 32'h0F);
        check("b2b_rx_data0", 32'(rx_data_o), 32'hA5);
        check("b2b_width0", 32'(width), 32'h1);
        xfer(8'h5A, 8, 8'hF0, mi, lat, width);
        check("b2b_master_rx1", 32'(mi), 32'hF0);
        check("b2b_rx_data1", 32'(rx_data_o), 32'h5A);
        check("b2b_width1", 32'(width), 32'h1);
        frame_end();

        // aborted frame, then a full one
        tx_data_i = 8'hFF;
        frame_start();
        xfer(8'hFF, 3, 8'hFF, mi, lat, width);
        frame_end();
        check("abort_no_valid", 32'(width), 32'h0);
        check("abort_rx_data", 32'(rx_data_o), 32'h5A);
        check("abort_miso", 32'(miso_o), 32'h0);
        tx_data_i = 8'h7E;
        frame_start();
        xfer(8'h81, 8, 8'h7E, mi, lat, width);
        check("after_abort_rx", 32'(rx_data_o), 32'h81);
        check("after_abort_master_rx", 32'(mi), 32'h7E);
        frame_end();

        // reset mid-frame
        tx_data_i = 8'h55;
        frame_start();
        xfer(8'h3C, 5, 8'h55, mi, lat, width);
        repeat (HALF) @(negedge clk);
        check("mid_busy", 32'(busy_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_miso", 32'(miso_o), 32'h0);
        check("arst_rx_data", 32'(rx_data_o), 32'h0);
        check("arst_rx_valid", 32'(rx_valid_o), 32'h0);
        check("arst_busy", 32'(busy_o), 32'h0);
        cs_n_i = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_data_i = 8'h96;
        frame_start();
        xfer(8'h3C, 8, 8'h96, mi, lat, width);
        check("post_rst_rx", 32'(rx_data_o), 32'h3C);
        check("post_rst_master_rx", 32'(mi), 32'h96);
        frame_end();

        // SCLK toggling while not selected
        for (int k = 0; k < 16; k++) begin
            sclk_i = ~sclk_i;
            repeat (HALF) @(negedge clk);
            check("idle_valid", 32'(rx_valid_o), 32'h0);
            check("idle_busy", 32'(busy_o), 32'h0);
            check("idle_miso", 32'(miso_o), 32'h0);
        end
        check("idle_rx_data", 32'(rx_data_o), 32'h3C);

`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack_i = 1'b0;
        tx_data_i = 8'h00;
        frame_start();
        xfer(8'h11, 8, 8'h00, mi, lat, width);
        check("ovr_valid1", 32'(rx_valid_o), 32'h1);
        check("ovr_data1", 32'(rx_data_o), 32'h11);
        check("ovr_flag1", 32'(overrun_o), 32'h0);
        xfer(8'h22, 8, 8'h00, mi, lat, width);
        check("ovr_valid2", 32'(rx_valid_o), 32'h1);
        check("ovr_data2", 32'(rx_data_o), 32'h22);
        check("ovr_flag2", 32'(overrun_o), 32'h1);
        frame_end();
        rx_ack_i = 1'b1;
        @(negedge clk);
        rx_ack_i = 1'b0;
        @(negedge clk);
        check("ovr_ack_valid", 32'(rx_valid_o), 32'h0);
        check("ovr_ack_flag", 32'(overrun_o), 32'h0);
        rx_ack_i = 1'b1;
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
